alu_cmp_iter_rv32i: RTL

//  Multi-cycle, parametrised compare unit serving SLT/SLTU/SLTI/SLTIU and branch conditions.

---
 rtl/alu_cmp_iter_rv32i.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_cmp_iter_rv32i.sv
// alu_cmp_iter_rv32i
//   Multi-cycle compare unit for SLT/SLTU/SLTI/SLTIU and branch conditions.
//   Operands are scanned MSB-first, CHUNK bits per BUSY cycle. The scan stops
//   at the first chunk that differs, so short compares finish early.
//   Optional feature macro: ALU_CMP_MINMAX_EN (adds Zbb MIN/MAX/MINU/MAXU via op[3]).
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   request valid
//   in_ready   out  unit can accept a request (IDLE)
//   in1, in2   in   operands A and B (XLEN)
//   op         in   [2:0] branch funct3 (EQ,NE,LT,GE,LTU,GEU), [3] min/max select
//   out_valid  out  result valid (DONE)
//   out_ready  in   consumer accepts result
//   flag       out  condition true
//   out        out  {zeros, flag} or min/max value
//   busy       out  state != IDLE
module alu_cmp_iter_rv32i #(
    parameter int XLEN  = 32,
    parameter int CHUNK = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    input  logic [3:0]      op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            flag,
    output logic [XLEN-1:0] out,
    output logic            busy
);

    localparam int NCHUNK = XLEN / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_in_ready;
    logic              r_out_valid;
    logic              r_busy;
    logic              r_flag;
    logic [XLEN-1:0]   r_out;
    logic [XLEN-1:0]   r_a;
    logic [XLEN-1:0]   r_b;
    logic [2:0]        r_op;
    logic              r_mm;
    logic [IDXW-1:0]   r_idx;

    logic              w_accept;
    logic              w_signed;
    logic [XLEN-1:0]   w_a_x;
    logic [XLEN-1:0]   w_b_x;
    logic [XLEN-1:0]   w_a_sh;
    logic [XLEN-1:0]   w_b_sh;
    logic [CHUNK-1:0]  w_a_chunk;
    logic [CHUNK-1:0]  w_b_chunk;
    logic              w_chunk_ne;
    logic              w_last;
    logic              w_fin;
    logic              w_lt;
    logic              w_eq;
    logic              w_flag_nxt;
    logic [XLEN-1:0]   w_out_nxt;

    // Branch-condition decode of the latched funct3.
    function automatic logic decode_flag(input logic [2:0] f3, input logic lt, input logic eq);
        logic res;
        case (f3)
            3'b000:          res = eq;
            3'b001:          res = !eq;
            3'b100, 3'b110:  res = lt;
            3'b101, 3'b111:  res = !lt;
            default:         res = 1'b0;
        endcase
        return res;
    endfunction

`ifdef ALU_CMP_MINMAX_EN
    // MIN/MAX are signed when op[1]=0; otherwise LT/GE are the signed branch ops.
    assign w_signed = r_mm ? !r_op[1] : (r_op[2:1] == 2'b10);
`else
    logic w_unused_op3;
    assign w_unused_op3 = op[3];
    assign w_signed     = (r_op[2:1] == 2'b10);
`endif

    assign w_accept = in_valid && r_in_ready;

    // Flipping the sign bit maps two's-complement order onto unsigned order,
    // so one unsigned chunk comparator serves every op.
    assign w_a_x      = r_a ^ {w_signed, {(XLEN-1){1'b0}}};
    assign w_b_x      = r_b ^ {w_signed, {(XLEN-1){1'b0}}};
    assign w_a_sh     = w_a_x << (int'(r_idx) * CHUNK);
    assign w_b_sh     = w_b_x << (int'(r_idx) * CHUNK);
    assign w_a_chunk  = w_a_sh[XLEN-1 -: CHUNK];
    assign w_b_chunk  = w_b_sh[XLEN-1 -: CHUNK];
    assign w_chunk_ne = (w_a_chunk != w_b_chunk);
    assign w_last     = (r_idx == IDXW'(NCHUNK - 1));
    assign w_fin      = (r_state == ST_BUSY) && (w_chunk_ne || w_last);
    assign w_lt       = w_chunk_ne && (w_a_chunk < w_b_chunk);
    assign w_eq       = !w_chunk_ne;

    // Next state and the result that is captured when the scan finishes.
    always_comb begin
        w_state_nxt = r_state;
        w_flag_nxt  = decode_flag(r_op, w_lt, w_eq);
        w_out_nxt   = {{(XLEN-1){1'b0}}, w_flag_nxt};
`ifdef ALU_CMP_MINMAX_EN
        if (r_mm) begin
            w_flag_nxt = w_lt;
            // op[0]=0 selects MIN; results come from the uninverted operands.
            if (r_op[0]) begin
                w_out_nxt = w_lt ? r_b : r_a;
            end else begin
                w_out_nxt = w_lt ? r_a : r_b;
            end
        end else begin
            w_out_nxt = {{(XLEN-1){1'b0}}, w_flag_nxt};
        end
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_BUSY;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (w_fin) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, handshake outputs, operand latch and scan index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_flag      <= 1'b0;
            r_out       <= {XLEN{1'b0}};
            r_a         <= {XLEN{1'b0}};
            r_b         <= {XLEN{1'b0}};
            r_op        <= 3'b000;
            r_mm        <= 1'b0;
            r_idx       <= {IDXW{1'b0}};
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt == ST_IDLE);
            r_out_valid <= (w_state_nxt == ST_DONE);
            r_busy      <= (w_state_nxt != ST_IDLE);
            if (w_accept) begin
                r_a    <= in1;
                r_b    <= in2;
                r_op   <= op[2:0];
`ifdef ALU_CMP_MINMAX_EN
                r_mm   <= op[3];
`else
                r_mm   <= 1'b0;
`endif
                r_idx  <= {IDXW{1'b0}};
                r_flag <= 1'b0;
                r_out  <= {XLEN{1'b0}};
            end else if (w_fin) begin
                r_flag <= w_flag_nxt;
                r_out  <= w_out_nxt;
            end else if (r_state == ST_BUSY) begin
                r_idx  <= r_idx + IDXW'(1);
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign flag      = r_flag;
    assign out       = r_out;

endmodule
